// File: rtl/inst_queue.sv
// Instruction queue between the Icache response port and ID decode: a DEPTH-entry
// first-word-fall-through FIFO of {pc, inst} with same-cycle bypass and a post-flush kill window.
module inst_queue #(
   parameter int DEPTH       = 4,
   parameter int XLEN        = 32,
   parameter bit BYPASS      = 1'b1,
   parameter int AFULL_TH    = DEPTH - 1,
   parameter int KILL_CYCLES = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       Icache_ready_i,
   input  logic [31:0]                Icache_inst_i,
   input  logic [XLEN-1:0]            Icache_pc_i,
   input  logic                       fc_stall_id_i,
   input  logic                       fc_flush_id_i,
   output logic                       iq_valid_o,
   output logic [31:0]                iq_inst_o,
   output logic [XLEN-1:0]            iq_pc_o,
   output logic [$clog2(DEPTH+1)-1:0] iq_count_o,
   output logic                       iq_full_o,
   output logic                       iq_afull_o,
   output logic                       iq_overflow_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);
   localparam logic [2:0]    KILL_C  = 3'(KILL_CYCLES);

   logic [31:0]     mem_inst [DEPTH];
   logic [XLEN-1:0] mem_pc   [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count, count_d;
   logic [2:0]      kill_cnt;
   logic            full_q, afull_q, ovf_q;

   logic kill, acc, has, byp, valid, pop, push, ovf_set;

   always_comb begin
      kill    = (kill_cnt != 3'd0);
      acc     = Icache_ready_i & ~fc_flush_id_i & ~kill;
      has     = (count != '0);
      byp     = BYPASS & ~has & acc & ~fc_stall_id_i;
      valid   = ~fc_flush_id_i & (has | byp);
      pop     = valid & ~fc_stall_id_i & has;
      push    = acc & ~byp & ((count < DEPTH_C) | pop);
      ovf_set = acc & ~byp & (count == DEPTH_C) & ~pop;
      count_d = fc_flush_id_i ? '0 : count + CW'(push) - CW'(pop);
   end

   // Head is read only while count > 0, so the unreset array never leaks to the outputs.
   always_comb begin
      iq_valid_o = valid;
      iq_inst_o  = '0;
      iq_pc_o    = '0;
      if (valid) begin
         iq_inst_o = has ? mem_inst[rd_ptr] : Icache_inst_i;
         iq_pc_o   = has ? mem_pc[rd_ptr]   : Icache_pc_i;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_inst[wr_ptr] <= Icache_inst_i;
         mem_pc[wr_ptr]   <= Icache_pc_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         kill_cnt <= 3'd0;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         count   <= count_d;
         full_q  <= (count_d == DEPTH_C);
         afull_q <= (count_d >= AFULL_C);
         if (ovf_set) ovf_q <= 1'b1;
         if (fc_flush_id_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            kill_cnt <= KILL_C;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (kill) kill_cnt <= kill_cnt - 3'd1;
         end
      end
   end

   assign iq_count_o    = count;
   assign iq_full_o     = full_q;
   assign iq_afull_o    = afull_q;
   assign iq_overflow_o = ovf_q;

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed test-plan sequences plus random traffic, checked against
// a queue-based behavioural model of the instruction queue.
module tb_inst_queue;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;
   localparam int KILL  = 2;
   localparam int AFTH  = DEPTH - 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            Icache_ready_i = 1'b0;
   logic [31:0]     Icache_inst_i = '0;
   logic [XLEN-1:0] Icache_pc_i = '0;
   logic            fc_stall_id_i = 1'b0;
   logic            fc_flush_id_i = 1'b0;
   logic            iq_valid_o;
   logic [31:0]     iq_inst_o;
   logic [XLEN-1:0] iq_pc_o;
   logic [2:0]      iq_count_o;
   logic            iq_full_o, iq_afull_o, iq_overflow_o;

   inst_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .BYPASS(1'b1), .AFULL_TH(AFTH), .KILL_CYCLES(KILL)) dut (
      .clk(clk), .rst_n(rst_n),
      .Icache_ready_i(Icache_ready_i), .Icache_inst_i(Icache_inst_i), .Icache_pc_i(Icache_pc_i),
      .fc_stall_id_i(fc_stall_id_i), .fc_flush_id_i(fc_flush_id_i),
      .iq_valid_o(iq_valid_o), .iq_inst_o(iq_inst_o), .iq_pc_o(iq_pc_o),
      .iq_count_o(iq_count_o), .iq_full_o(iq_full_o), .iq_afull_o(iq_afull_o),
      .iq_overflow_o(iq_overflow_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   entry_t q[$];
   int     kill_left = 0;
   bit     m_ovf = 1'b0;
   int     n_assert = 0;
   int     n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive at posedge+1, check combinational and registered outputs, then advance.
   task automatic step(input bit rdy, input logic [31:0] ins, input logic [31:0] p,
                       input bit st, input bit fl);
      bit          accept, byp, e_valid;
      logic [31:0] e_inst, e_pc;
      entry_t      e;
      Icache_ready_i = rdy; Icache_inst_i = ins; Icache_pc_i = p;
      fc_stall_id_i = st; fc_flush_id_i = fl;
      #1;
      accept = rdy && !fl && kill_left == 0;
      byp = 1'b0; e_valid = 1'b0; e_inst = '0; e_pc = '0;
      if (!fl) begin
         if (q.size() > 0) begin
            e_valid = 1'b1; e_inst = q[0].inst; e_pc = q[0].pc;
         end else if (accept && !st) begin
            byp = 1'b1; e_valid = 1'b1; e_inst = ins; e_pc = p;
         end
      end
      chk("valid", 64'(iq_valid_o), 64'(e_valid));
      chk("inst", 64'(iq_inst_o), 64'(e_inst));
      chk("pc", 64'(iq_pc_o), 64'(e_pc));
      chk("count", 64'(iq_count_o), 64'(q.size()));
      chk("full", 64'(iq_full_o), 64'(q.size() == DEPTH));
      chk("afull", 64'(iq_afull_o), 64'(q.size() >= AFTH));
      chk("overflow", 64'(iq_overflow_o), 64'(m_ovf));
      if (fl) begin
         q.delete();
         kill_left = KILL;
      end else begin
         if (e_valid && !st && !byp) void'(q.pop_front());
         if (accept && !byp) begin
            if (q.size() < DEPTH) begin
               e.pc = p; e.inst = ins; q.push_back(e);
            end else m_ovf = 1'b1;
         end
         if (kill_left > 0) kill_left--;
      end
      @(posedge clk); #1;
   endtask

   // Assert reset mid-cycle and check the outputs clear without waiting for a clock edge.
   task automatic do_reset();
      Icache_ready_i = 1'b0; fc_stall_id_i = 1'b0; fc_flush_id_i = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_valid", 64'(iq_valid_o), 64'd0);
      chk("rst_inst", 64'(iq_inst_o), 64'd0);
      chk("rst_pc", 64'(iq_pc_o), 64'd0);
      chk("rst_count", 64'(iq_count_o), 64'd0);
      chk("rst_full", 64'(iq_full_o), 64'd0);
      chk("rst_afull", 64'(iq_afull_o), 64'd0);
      chk("rst_ovf", 64'(iq_overflow_o), 64'd0);
      q.delete(); kill_left = 0; m_ovf = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      @(posedge clk); #1;
      do_reset();

      // Bypass of a single word into an empty queue.
      step(1, 32'h0050_0093, 32'h100, 0, 0);
      chk("bypass_count", 64'(iq_count_o), 64'd0);

      // Stall fill past capacity, then drain in order.
      for (int i = 1; i <= 6; i++) step(1, 32'h1000 + 32'(i), 32'h200 + 32'(4 * i), 1, 0);
      chk("fill_full", 64'(iq_full_o), 64'd1);
      chk("fill_ovf", 64'(iq_overflow_o), 64'd1);
      for (int i = 0; i < 4; i++) step(0, '0, '0, 0, 0);
      chk("drained", 64'(iq_count_o), 64'd0);
      do_reset();

      // Full queue with a simultaneous pop and push.
      for (int i = 1; i <= 4; i++) step(1, 32'h2000 + 32'(i), 32'h300 + 32'(4 * i), 1, 0);
      step(1, 32'h2005, 32'h314, 0, 0);
      chk("fullpp_count", 64'(iq_count_o), 64'd4);
      chk("fullpp_ovf", 64'(iq_overflow_o), 64'd0);
      for (int i = 0; i < 4; i++) step(0, '0, '0, 0, 0);

      // Flush with three stored words and a two-cycle kill window.
      for (int i = 1; i <= 3; i++) step(1, 32'h3000 + 32'(i), 32'h400 + 32'(4 * i), 1, 0);
      step(1, 32'h3004, 32'h410, 0, 1);
      chk("flush_count", 64'(iq_count_o), 64'd0);
      step(1, 32'h3005, 32'h414, 0, 0);
      step(1, 32'h3006, 32'h418, 0, 0);
      step(1, 32'h3007, 32'h41c, 0, 0);

      // Stall and flush together.
      for (int i = 1; i <= 2; i++) step(1, 32'h4000 + 32'(i), 32'h500 + 32'(4 * i), 1, 0);
      step(0, '0, '0, 1, 1);
      chk("stallflush_count", 64'(iq_count_o), 64'd0);
      for (int i = 0; i < KILL; i++) step(0, '0, '0, 0, 0);

      // Async reset with two stored words, then with the kill window open.
      for (int i = 1; i <= 2; i++) step(1, 32'h5000 + 32'(i), 32'h600 + 32'(4 * i), 1, 0);
      do_reset();
      step(1, 32'h5003, 32'h608, 0, 0);
      step(0, '0, '0, 0, 1);
      do_reset();
      step(1, 32'h5004, 32'h60c, 0, 0);

      // Random traffic.
      for (int i = 0; i < 600; i++)
         step($urandom_range(3, 0) != 0, $urandom, $urandom,
              $urandom_range(9, 0) < 4, $urandom_range(19, 0) == 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
